mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised N-port memory arbiter that serialises independent requesters onto a single memory port. It is the successor to the inout-bus port multiplexer, with point-to-point request/grant/done handshakes, selectable round-robin or fixed priority, and a bounded-wait timeout with error reporting. It sits between the PE/line-buffer clients and the near-memory bank controller.

## Interface
- NUM_PORTS, 9, number of requesters (≥2)
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 32, data width
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed (lowest index wins)
- TIMEOUT, 64, max cycles waiting for mem_ack; 0 disables timeout

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- port_req  in  NUM_PORTS  per-port request
- port_we  in  NUM_PORTS  1 = write, 0 = read
- port_addr  in  NUM_PORTS×ADDR_WIDTH  per-port address
- port_wdata  in  NUM_PORTS×DATA_WIDTH  per-port write data
- port_gnt  out  NUM_PORTS  one-cycle pulse: request captured
- port_done  out  NUM_PORTS  one-cycle pulse: transaction finished
- port_err  out  1  valid with port_done; 1 = timed out
- port_rdata  out  DATA_WIDTH  read data, valid with port_done
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ack  in  1  completion, sampled only while mem_req=1
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack

## Operation
- FSM states: IDLE, MEM, DONE.
- IDLE: if any port_req, picker selects winner; register we/addr/wdata and winner index; pulse port_gnt[winner]; → MEM. No request → stay.
- MEM: mem_req=1 with registered fields. On mem_ack: capture mem_rdata, err=0, → DONE. If TIMEOUT≠0 and wait counter reaches TIMEOUT−1 without ack: err=1, rdata=0, → DONE.
- DONE: port_done[winner]=1, port_err/port_rdata driven; update pointer; → IDLE.
- Round-robin: search starts at rr_ptr and wraps; after DONE, rr_ptr = (winner+1) mod NUM_PORTS (wrap NUM_PORTS−1 → 0). Fixed mode: rr_ptr ignored.
- Port rules: hold req/we/addr/wdata stable until port_gnt; a req still high when FSM re-enters IDLE is a new transaction.
- Write transactions: port_rdata = 0 on done.
- Reset values: all outputs 0, state IDLE, rr_ptr 0, counter 0. Reset mid-transaction aborts it: no done pulse, mem_req drops immediately.

## Timing
- All outputs registered.
- Req sampled in IDLE at edge k → port_gnt and mem_req high in cycle k+1.
- mem_ack in first MEM cycle → port_done in cycle k+2 (minimum latency 2).
- Min throughput: one transaction per 3 cycles (IDLE, MEM, DONE).
- Timeout: mem_req high exactly TIMEOUT cycles, then DONE with err.
- mem_ack outside MEM is ignored.
- Simultaneous requests: exactly one grant per IDLE visit; port_gnt and port_done are never multi-hot.

## Structure
- Package mem_arb_pkg: state enum, PRIO_RR/PRIO_FIXED constants.
- Sub-module mem_arb_picker: combinational rotating-base priority picker (req vector, base index → one-hot + index, any_valid); base forced to 0 in fixed mode.
- Wait counter width $clog2(TIMEOUT+1).

## Test plan
- Port 3 write addr 0x0010 data 0xDEADBEEF, ack in first MEM cycle → gnt[3] at k+1, mem_we=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF, done[3] at k+2, err=0.
- Port 1 read addr 0x00A0, ack after 3 MEM cycles with mem_rdata 0x12345678 → port_rdata=0x12345678 with done[1], err=0.
- Mode 0, ports 0,4,8 requesting continuously → grant order 0,4,8,0,4; pointer wraps 8→0.
- Mode 1, ports 2 and 5 requesting continuously → port 2 granted every transaction; port 5 never.
- TIMEOUT=8, no ack → mem_req high 8 cycles, then done with err=1, rdata=0; late ack ignored.
- rst asserted during MEM → all outputs 0 immediately, no done; after release with ports 0 and 6 requesting, mode 0 → port 0 granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the N-port memory arbiter
// Revision    : 1.0
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_picker : combinational rotating-base priority picker
// Revision       : 1.0
// ----------------------------------------------------------------------------
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 9,
  parameter int PRIORITY_MODE = PRIO_RR,
  parameter int IDX_W         = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     base,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 any_valid
);

  logic [IDX_W-1:0] base_eff;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Fixed priority is simply a rotation that always starts at port 0.
  assign base_eff = (PRIORITY_MODE == PRIO_FIXED) ? '0 : base;

  always_comb begin
    onehot    = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(base_eff) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (!any_valid && req[cand_idx]) begin
        any_valid        = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_rr : N-port request/grant/done arbiter onto one memory port
// Revision       : 1.0
// ----------------------------------------------------------------------------
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 9,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_req,
  input  logic [NUM_PORTS-1:0]             port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_gnt,
  output logic [NUM_PORTS-1:0]             port_done,
  output logic                             port_err,
  output logic [DATA_WIDTH-1:0]            port_rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t             state;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       wait_cnt;

  logic [NUM_PORTS-1:0]   pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  mem_arb_picker #(
    .NUM_PORTS     (NUM_PORTS),
    .PRIORITY_MODE (PRIORITY_MODE),
    .IDX_W         (IDX_W)
  ) u_picker (
    .req       (port_req),
    .base      (rr_ptr),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .any_valid (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      winner     <= '0;
      rr_ptr     <= '0;
      wait_cnt   <= '0;
      port_gnt   <= '0;
      port_done  <= '0;
      port_err   <= 1'b0;
      port_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Grant/done/err/rdata are single-cycle pulses by default.
      port_gnt   <= '0;
      port_done  <= '0;
      port_err   <= 1'b0;
      port_rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            winner    <= pick_idx;
            port_gnt  <= pick_onehot;
            mem_req   <= 1'b1;
            mem_we    <= port_we[pick_idx];
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            wait_cnt  <= '0;
            state     <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            port_done  <= NUM_PORTS'(1) << winner;
            port_rdata <= mem_we ? '0 : mem_rdata;
            state      <= ST_DONE;
          end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            port_done <= NUM_PORTS'(1) << winner;
            port_err  <= 1'b1;
            state     <= ST_DONE;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          rr_ptr <= (winner == IDX_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter_rr : directed + randomized bench, round-robin and fixed DUTs
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter_rr;

  localparam int N   = 9;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we  = '0;
  logic [N*AW-1:0] addr_bus = '0;
  logic [N*DW-1:0] wd_bus   = '0;
  logic            mem_ack  = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  logic [N-1:0]  gnt_a, done_a, gnt_b, done_b;
  logic          err_a, err_b, mreq_a, mreq_b, mwe_a, mwe_b;
  logic [DW-1:0] rdata_a, rdata_b, mwd_a, mwd_b;
  logic [AW-1:0] madr_a, madr_b;

  bit sel = 1'b0;   // 0 observes round-robin DUT, 1 observes fixed-priority DUT
  int m_ptr = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .PRIORITY_MODE(0), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .rst(rst), .port_req(req), .port_we(we), .port_addr(addr_bus),
    .port_wdata(wd_bus), .port_gnt(gnt_a), .port_done(done_a), .port_err(err_a),
    .port_rdata(rdata_a), .mem_req(mreq_a), .mem_we(mwe_a), .mem_addr(madr_a),
    .mem_wdata(mwd_a), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .PRIORITY_MODE(1), .TIMEOUT(TMO)) dut_fx (
    .clk(clk), .rst(rst), .port_req(req), .port_we(we), .port_addr(addr_bus),
    .port_wdata(wd_bus), .port_gnt(gnt_b), .port_done(done_b), .port_err(err_b),
    .port_rdata(rdata_b), .mem_req(mreq_b), .mem_we(mwe_b), .mem_addr(madr_b),
    .mem_wdata(mwd_b), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  logic [N-1:0]  o_gnt, o_done;
  logic          o_err, o_mreq, o_mwe;
  logic [DW-1:0] o_rdata, o_mwd;
  logic [AW-1:0] o_madr;
  assign o_gnt   = sel ? gnt_b   : gnt_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_err   = sel ? err_b   : err_a;
  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_mreq  = sel ? mreq_b  : mreq_a;
  assign o_mwe   = sel ? mwe_b   : mwe_a;
  assign o_madr  = sel ? madr_b  : madr_a;
  assign o_mwd   = sel ? mwd_b   : mwd_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = w;
    addr_bus[p*AW +: AW] = a;
    wd_bus[p*DW +: DW] = d;
  endtask

  // Winner = requester at smallest circular distance from the search base.
  function automatic int model_pick(input logic [N-1:0] r, input bit fixed);
    int best = -1;
    int bd = N;
    int base = fixed ? 0 : m_ptr;
    for (int p = 0; p < N; p++) begin
      if (r[p] && ((p - base + N) % N) < bd) begin
        bd = (p - base + N) % N;
        best = p;
      end
    end
    return best;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, o_gnt, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_rdata"}, o_rdata, 0);
    chk({tag, "_mreq"}, o_mreq, 0);
    chk({tag, "_mwe"}, o_mwe, 0);
    chk({tag, "_maddr"}, o_madr, 0);
    chk({tag, "_mwdata"}, o_mwd, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // One full transaction: expects port w granted, ack in MEM cycle dly (-1: never).
  task automatic do_txn(input int w, input int dly, input logic [DW-1:0] rd, input bit keep);
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    bit            fin;
    int            j;
    ewe = we[w];
    ea  = addr_bus[w*AW +: AW];
    ewd = wd_bus[w*DW +: DW];
    @(posedge clk); #1;
    chk("gnt", o_gnt, N'(1) << w);
    chk("mem_req_on", o_mreq, 1);
    chk("mem_we", o_mwe, ewe);
    chk("mem_addr", o_madr, ea);
    chk("mem_wdata", o_mwd, ewd);
    chk("done_at_gnt", o_done, 0);
    if (keep) set_port(w, 1'($urandom), 16'($urandom), $urandom);
    else req[w] = 1'b0;
    fin = 0;
    j = 0;
    while (!fin) begin
      mem_ack = (j == dly);
      mem_rdata = (j == dly) ? rd : $urandom;
      @(posedge clk); #1;
      if (j == dly || j == TMO - 1) begin
        fin = 1;
        chk("done", o_done, N'(1) << w);
        chk("err", o_err, (j == dly) ? 0 : 1);
        chk("rdata", o_rdata, (j == dly && !ewe) ? rd : 0);
        chk("mem_req_off", o_mreq, 0);
        chk("gnt_in_done", o_gnt, 0);
      end else begin
        chk("mem_req_hold", o_mreq, 1);
        chk("done_early", o_done, 0);
        chk("gnt_hold", o_gnt, 0);
      end
      j++;
    end
    // Acks outside MEM (late ack in DONE, stray ack in IDLE) must be ignored.
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'($urandom);
    chk("done_cleared", o_done, 0);
    chk("err_cleared", o_err, 0);
    chk("rdata_cleared", o_rdata, 0);
    chk("mem_req_idle", o_mreq, 0);
    if (!sel) m_ptr = (w + 1) % N;
  endtask

  task automatic random_phase(input int cnt, input bit fixed);
    int w;
    for (int t = 0; t < cnt; t++) begin
      for (int p = 0; p < N; p++) begin
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          set_port(p, 1'($urandom), 16'($urandom), $urandom);
          req[p] = 1'b1;
        end
      end
      if (req == '0) begin
        w = $urandom_range(0, N - 1);
        set_port(w, 1'($urandom), 16'($urandom), $urandom);
        req[w] = 1'b1;
      end
      w = model_pick(req, fixed);
      do_txn(w, $urandom_range(0, 10), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_all_zero("reset_async");
    do_reset();
    check_all_zero("after_reset");

    // Port 3 write, ack in first MEM cycle
    set_port(3, 1'b1, 16'h0010, 32'hDEADBEEF);
    req[3] = 1'b1;
    do_txn(3, 0, 32'h0, 1'b0);

    // Port 1 read, ack in third MEM cycle
    set_port(1, 1'b0, 16'h00A0, 32'h0);
    req[1] = 1'b1;
    do_txn(1, 2, 32'h12345678, 1'b0);

    // Timeout on port 7, followed by late ack
    set_port(7, 1'b0, 16'h0777, 32'h0);
    req[7] = 1'b1;
    do_txn(7, -1, 32'hCAFEF00D, 1'b0);

    // Reset in MEM aborts the transaction; ports 0 and 6 then resume from port 0
    mem_ack = 1'b0;
    set_port(0, 1'b0, 16'h1000, 32'h0);
    set_port(6, 1'b1, 16'h6000, 32'h66666666);
    req = N'((1 << 0) | (1 << 6));
    @(posedge clk); #1;
    chk("pre_rst_gnt", o_gnt, N'(1) << model_pick(req, 1'b0));
    @(posedge clk); #1;
    chk("pre_rst_mreq", o_mreq, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    chk("rst_no_done", o_done, 0);
    rst = 1'b0;
    m_ptr = 0;
    do_txn(0, 1, 32'hA5A5A5A5, 1'b0);
    req = '0;

    // Round-robin rotation over ports 0, 4, 8 with wrap
    do_reset();
    req = N'((1 << 0) | (1 << 4) | (1 << 8));
    do_txn(0, 0, $urandom, 1'b1);
    do_txn(4, 1, $urandom, 1'b1);
    do_txn(8, 0, $urandom, 1'b1);
    do_txn(0, 0, $urandom, 1'b1);
    do_txn(4, 0, $urandom, 1'b1);
    req = '0;

    // Fixed priority: port 2 always beats port 5
    do_reset();
    sel = 1'b1;
    req = N'((1 << 2) | (1 << 5));
    for (int t = 0; t < 4; t++) do_txn(2, t, $urandom, 1'b1);
    req = '0;

    // Randomized round-robin then fixed-priority traffic
    do_reset();
    sel = 1'b0;
    random_phase(40, 1'b0);
    req = '0;
    do_reset();
    sel = 1'b1;
    random_phase(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
